// File: rtl/key_debounce.sv
// key_debounce
//
// Turns the raw calculator keypad into clean single-cycle key strobes for the
// calculator core. The 14 raw key lines are synchronised, a single key must be
// seen stable for DEB_CYCLES+1 consecutive samples before it strobes, and the
// keypad must then read all-released for DEB_CYCLES+1 consecutive samples
// before another key is accepted. Chords (two or more keys together) are
// never accepted as a new press.
//
// Parameters
//   DEB_CYCLES : stable samples required beyond the first (1 .. 2^CNT_W-1)
//   CNT_W      : width of the debounce counter
//
// Ports
//   CLK       : system clock, rising edge
//   RST       : synchronous reset, active low
//   raw_key   : asynchronous active-high buttons
//               [9:0] digits 0-9, [10] plus, [11] minus, [12] equal, [13] ce
//   decimal   : one-hot digit strobe, bit n is digit n
//   plus      : plus strobe
//   minus     : minus strobe
//   equal     : equal strobe
//   ce        : clear-entry strobe
//   busy      : high whenever the FSM is not idle
//   state_dbg : current FSM state (IDLE=0, PRESS=1, FIRE=2, HOLD=3, RELEASE=4)

module key_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 18
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [13:0] raw_key,
    output logic [9:0]  decimal,
    output logic        plus,
    output logic        minus,
    output logic        equal,
    output logic        ce,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PRESS   = 3'd1,
        FIRE    = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    // Counter value on the last required stable sample.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [13:0]       s1;
    logic [13:0]       s2;
    logic [13:0]       code;
    logic [13:0]       code_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              s2_onehot;

    // Two-flop synchroniser on every key line.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_key;
            s2 <= s1;
        end
    end

    // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
    assign s2_onehot = (s2 != '0) && ((s2 & (s2 - 14'd1)) == '0);

    // State register together with the captured key and debounce counter.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
            code  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            code  <= code_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic. The counter is compared before it is incremented, so
    // it never exceeds CNT_LAST and cannot wrap.
    always_comb begin
        state_nxt = state;
        code_nxt  = code;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (s2_onehot) begin
                    code_nxt  = s2;
                    cnt_nxt   = '0;
                    state_nxt = PRESS;
                end
            end
            PRESS: begin
                if (s2 != code) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FIRE;
                end else begin
                    cnt_nxt = CNT_W'(cnt + 1'b1);
                end
            end
            FIRE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                // Extra keys while held are ignored; only a full release counts.
                if (s2 == '0) begin
                    cnt_nxt   = '0;
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (s2 != '0) begin
                    state_nxt = HOLD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = CNT_W'(cnt + 1'b1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode. code is one-hot, so at most one strobe is ever high.
    always_comb begin
        decimal = '0;
        plus    = 1'b0;
        minus   = 1'b0;
        equal   = 1'b0;
        ce      = 1'b0;
        busy    = (state != IDLE);
        if (state == FIRE) begin
            decimal = code[9:0];
            plus    = code[10];
            minus   = code[11];
            equal   = code[12];
            ce      = code[13];
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_key_debounce.sv
`timescale 1ns/1ps

module tb_key_debounce;

    localparam int DEB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [13:0] raw_key = '0;
    logic [9:0]  decimal;
    logic        plus;
    logic        minus;
    logic        equal;
    logic        ce;
    logic        busy;
    logic [2:0]  state_dbg;

    logic [13:0] dut_vec;
    assign dut_vec = {ce, equal, minus, plus, decimal};

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    key_debounce #(.DEB_CYCLES(DEB), .CNT_W(18)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .raw_key   (raw_key),
        .decimal   (decimal),
        .plus      (plus),
        .minus     (minus),
        .equal     (equal),
        .ce        (ce),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- behavioural model ----------------
    // Expressed as runs of identical synchronised samples: a lone key must be
    // seen DEB+1 times in a row to strobe; after the strobe, the keypad must
    // read empty DEB+1 times in a row before a new key is looked at.
    logic [13:0] m_s1 = '0;
    logic [13:0] m_s2 = '0;
    logic [13:0] m_cand = '0;      // key currently being qualified
    logic [13:0] m_strobe = '0;    // strobe expected this cycle
    int          m_run = 0;        // consecutive samples of m_cand seen
    int          m_rel_run = 0;    // consecutive empty samples while held
    bit          m_held = 1'b0;    // a key has strobed and not yet been released
    bit          m_busy = 1'b0;

    always @(posedge CLK) begin
        logic [13:0] v;
        logic [13:0] nxt;
        v   = m_s2;
        nxt = '0;
        if (!RST) begin
            m_s1 = '0; m_s2 = '0; m_cand = '0; m_strobe = '0;
            m_run = 0; m_rel_run = 0; m_held = 1'b0;
        end else begin
            if (m_strobe != '0) begin
                m_held = 1'b1;
                m_rel_run = 0;
            end else if (m_held) begin
                if (v == '0) begin
                    m_rel_run++;
                    if (m_rel_run == DEB + 1) begin
                        m_held = 1'b0;
                        m_rel_run = 0;
                    end
                end else begin
                    m_rel_run = 0;
                end
            end else if (m_cand != '0) begin
                if (v == m_cand) begin
                    m_run++;
                    if (m_run == DEB + 1) begin
                        nxt = m_cand;
                        m_cand = '0;
                        m_run = 0;
                    end
                end else begin
                    m_cand = '0;
                    m_run = 0;
                end
            end else if ($countones(v) == 1) begin
                m_cand = v;
                m_run = 1;
            end
            m_strobe = nxt;
            m_s2 = m_s1;
            m_s1 = raw_key;
        end
        m_busy = m_held || (m_cand != '0) || (m_strobe != '0);
    end

    // ---------------- scoreboard / compare process ----------------
    logic [13:0] exp_q[$];
    bit          chk_en = 1'b0;
    bit          sb_en = 1'b0;
    bit          sb_final = 1'b0;
    bit          sb_final_done = 1'b0;
    bit          pin_en = 1'b0;
    logic [13:0] pin_vec = '0;
    logic        pin_busy = 1'b0;
    string       pin_name = "";

    always @(negedge CLK) begin
        if (chk_en) begin
            checks++;
            if (dut_vec !== m_strobe || busy !== m_busy) begin
                errors++;
                $display("FAIL cycle_model t=%0t state=%0d got strobes=%b busy=%b expected strobes=%b busy=%b",
                         $time, state_dbg, dut_vec, busy, m_strobe, m_busy);
            end
            if (pin_en) begin
                checks++;
                if (dut_vec !== pin_vec || busy !== pin_busy) begin
                    errors++;
                    $display("FAIL %s dut t=%0t got strobes=%b busy=%b expected strobes=%b busy=%b",
                             pin_name, $time, dut_vec, busy, pin_vec, pin_busy);
                end
                checks++;
                if (m_strobe !== pin_vec || m_busy !== pin_busy) begin
                    errors++;
                    $display("FAIL %s model t=%0t got strobes=%b busy=%b expected strobes=%b busy=%b",
                             pin_name, $time, m_strobe, m_busy, pin_vec, pin_busy);
                end
            end
            if (sb_en && dut_vec != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL seq_order t=%0t got strobe %b expected none", $time, dut_vec);
                end else begin
                    logic [13:0] e;
                    e = exp_q.pop_front();
                    if (dut_vec !== e) begin
                        errors++;
                        $display("FAIL seq_order t=%0t got strobe %b expected %b", $time, dut_vec, e);
                    end
                end
            end
            if (sb_final && !sb_final_done) begin
                sb_final_done = 1'b1;
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL seq_complete got %0d strobes outstanding expected 0", exp_q.size());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Advance n rising edges; inputs change 2 ns after the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    // Pin the DUT and model to a literal in the current cycle.
    task automatic expect_now(input string name, input logic [13:0] vec, input logic b);
        pin_name = name;
        pin_vec  = vec;
        pin_busy = b;
        pin_en   = 1'b1;
        @(negedge CLK);
        #1;
        pin_en   = 1'b0;
    endtask

    task automatic press_release(input int k, input int hold_c, input int rel_c);
        raw_key = 14'(1 << k);
        step(hold_c);
        raw_key = '0;
        step(rel_c);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset release
        RST = 1'b0;
        raw_key = '0;
        @(posedge CLK);
        #2;
        chk_en = 1'b1;
        step(2);
        expect_now("reset_outputs", 14'd0, 1'b0);
        RST = 1'b1;
        step(20);
        expect_now("reset_quiet", 14'd0, 1'b0);

        // Clean digit 7: strobe after the 7th edge from the input change
        raw_key = 14'(1 << 7);
        step(6);
        expect_now("digit7_before", 14'd0, 1'b1);
        step(1);
        expect_now("digit7_strobe", 14'b00_0000_1000_0000, 1'b1);
        step(1);
        expect_now("digit7_after", 14'd0, 1'b1);
        step(12);
        raw_key = '0;
        step(6);
        expect_now("digit7_release_busy", 14'd0, 1'b1);
        step(1);
        expect_now("digit7_release_idle", 14'd0, 1'b0);
        step(10);

        // Bounce on plus, then a release glitch
        raw_key = 14'(1 << 10); step(1);
        raw_key = '0;           step(1);
        raw_key = 14'(1 << 10); step(1);
        raw_key = '0;           step(1);
        raw_key = 14'(1 << 10);
        step(6);
        expect_now("plus_before", 14'd0, 1'b1);
        step(1);
        expect_now("plus_strobe", 14'h0400, 1'b1);
        step(8);
        raw_key = '0;           step(2);
        raw_key = 14'(1 << 10); step(2);
        raw_key = '0;           step(15);
        expect_now("plus_no_second", 14'd0, 1'b0);

        // Chord, then drop one key
        raw_key = 14'(1 << 3) | 14'(1 << 11);
        step(15);
        expect_now("chord_ignored", 14'd0, 1'b0);
        raw_key = 14'(1 << 11);
        step(6);
        expect_now("minus_before", 14'd0, 1'b1);
        step(1);
        expect_now("minus_strobe", 14'h0800, 1'b1);
        step(8);
        raw_key = '0;
        step(15);

        // Reset in the cycle before FIRE, key held throughout
        raw_key = 14'(1 << 13);
        step(6);
        expect_now("ce_pressing", 14'd0, 1'b1);
        RST = 1'b0;
        step(1);
        expect_now("ce_dropped", 14'd0, 1'b0);
        step(1);
        RST = 1'b1;
        step(6);
        expect_now("ce_rearm_before", 14'd0, 1'b1);
        step(1);
        expect_now("ce_rearm_strobe", 14'h2000, 1'b1);
        step(1);
        expect_now("ce_rearm_after", 14'd0, 1'b1);
        raw_key = '0;
        step(15);

        // Sequence 1, 2, plus, 3, equal
        sb_en = 1'b1;
        foreach (exp_q[i]) exp_q.delete(i);
        begin
            int keys[5];
            keys = '{1, 2, 10, 3, 12};
            for (int i = 0; i < 5; i++) begin
                exp_q.push_back(14'(1 << keys[i]));
                press_release(keys[i], 12, 12);
            end
        end
        step(10);
        sb_en = 1'b0;
        sb_final = 1'b1;
        step(2);

        // Randomised stimulus against the model
        for (int seg = 0; seg < 300; seg++) begin
            int sel;
            int dur;
            sel = $urandom_range(0, 9);
            dur = $urandom_range(1, 14);
            if (sel <= 3) begin
                raw_key = '0;
            end else if (sel <= 7) begin
                raw_key = 14'(1 << $urandom_range(0, 13));
            end else if (sel == 8) begin
                raw_key = 14'(1 << $urandom_range(0, 13)) | 14'(1 << $urandom_range(0, 13));
            end else begin
                raw_key = 14'($urandom_range(0, 16383));
            end
            if ($urandom_range(0, 39) == 0) begin
                RST = 1'b0;
                step($urandom_range(1, 2));
                RST = 1'b1;
            end
            step(dur);
        end
        raw_key = '0;
        step(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
